// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte queue that feeds uart_tx one byte at a time.
// Ports: clk/rst_n; wr_en/wr_data push side; flush clears queued bytes;
//   full/empty/level/overflow status; uart_tx_send/data/done/busy link.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              uart_tx_send,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_tx_done,
  input  logic              uart_tx_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_state;
  logic              r_overflow;
  logic              r_send;
  logic [7:0]        r_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Full is judged on the registered count, so a pop in the
  // same cycle never makes room for a write.
  assign w_push = wr_en && !w_full && !flush;
  assign w_pop  = (r_state == S_IDLE) && !w_empty &&
                  !uart_tx_busy && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && w_full && !flush;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CNT_ONE;
        end
      end
    end
  end

  // Flush leaves the sequencer alone so an in-flight byte finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_send  <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_send <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_data  <= r_mem[r_rd_ptr];
            r_send  <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: r_state <= S_WAIT;
        S_WAIT: begin
          if (uart_tx_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign level        = r_count;
  assign overflow     = r_overflow;
  assign uart_tx_send = r_send;
  assign uart_tx_data = r_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench with a queue-based reference model
// and a simple uart_tx responder.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       full, empty, overflow;
  logic [4:0] level;
  logic       uart_tx_send;
  logic [7:0] uart_tx_data;
  logic       uart_tx_done, uart_tx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .level(level),
    .overflow(overflow),
    .uart_tx_send(uart_tx_send), .uart_tx_data(uart_tx_data),
    .uart_tx_done(uart_tx_done), .uart_tx_busy(uart_tx_busy)
  );

  // uart_tx responder: busy after a send, done u_dly cycles later
  logic u_busy = 1'b0;
  logic u_done = 1'b0;
  logic force_busy = 1'b0;
  int   u_cnt = 0;
  int   u_dly = 100;

  assign uart_tx_busy = u_busy | force_busy;
  assign uart_tx_done = u_done;

  always @(negedge clk) begin
    u_done = 1'b0;
    if (uart_tx_send === 1'b1) begin
      u_busy = 1'b1;
      u_cnt  = u_dly;
    end else if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        u_done = 1'b1;
        u_busy = 1'b0;
      end
    end
  end

  // Reference model: a queue of bytes plus the sender's phase
  // (0 ready, 1 just sent, 2 waiting for done).
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_send = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_phase = 0;
  bit         m_start, m_was_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_send = 1'b0;
      m_data = 8'h00;
      m_phase = 0;
    end else begin
      m_was_full = (mq.size() == 16);
      m_start = (m_phase == 0) && (mq.size() != 0) &&
                !uart_tx_busy && !flush;
      m_ovf = wr_en && m_was_full && !flush;
      m_send = m_start;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_start) m_data = mq.pop_front();
        if (wr_en && !m_was_full) mq.push_back(wr_data);
      end
      if (m_start) m_phase = 1;
      else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && uart_tx_done) m_phase = 0;
    end
  end

  task automatic cmp(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  logic [7:0] sent[$];
  logic [7:0] exp_q[$];
  int nsend = 0;

  always @(negedge clk) begin
    cmp("level", level, mq.size());
    cmp("full", full, mq.size() == 16);
    cmp("empty", empty, mq.size() == 0);
    cmp("overflow", overflow, m_ovf);
    cmp("send", uart_tx_send, m_send);
    cmp("data", uart_tx_data, m_data);
    if (uart_tx_send === 1'b1) begin
      sent.push_back(uart_tx_data);
      nsend++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string n);
    int k = 0;
    while (!(mq.size() == 0 && m_phase == 0 && !u_busy) && k < 5000) begin
      step();
      k++;
    end
    cmp(n, k < 5000, 1);
  endtask

  task automatic wait_wait(input string n);
    int k = 0;
    while (m_phase != 2 && k < 500) begin
      step();
      k++;
    end
    cmp(n, k < 500, 1);
  endtask

  task automatic check_log(input string n);
    cmp({n, "_len"}, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
      cmp(n, sent[i], exp_q[i]);
  endtask

  string msg;
  logic [7:0] b;
  int n, k, nb;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    repeat (20) step();
    cmp("idle_empty", empty, 1);
    cmp("idle_level", level, 0);
    cmp("idle_data", uart_tx_data, 8'h00);
    cmp("idle_nsend", nsend, 0);

    sent.delete();
    push(8'h42);
    cmp("p42_level1", level, 1);
    cmp("p42_nosend", uart_tx_send, 0);
    step();
    cmp("p42_send", uart_tx_send, 1);
    cmp("p42_data", uart_tx_data, 8'h42);
    cmp("p42_level0", level, 0);
    step();
    cmp("p42_send_low", uart_tx_send, 0);
    wait_idle("p42_idle");
    cmp("p42_count", sent.size(), 1);

    msg = "Baptiste !\n";
    sent.delete();
    exp_q.delete();
    for (int i = 0; i < msg.len(); i++) begin
      exp_q.push_back(msg[i]);
      push(msg[i]);
    end
    wait_idle("burst_idle");
    check_log("burst");
    cmp("burst_empty", empty, 1);
    cmp("burst_first", sent.size() > 0 ? sent[0] : 8'hxx, 8'h42);

    sent.delete();
    exp_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    cmp("full_flag", full, 1);
    cmp("full_level", level, 16);
    push(8'h10);
    cmp("ovf_pulse", overflow, 1);
    cmp("ovf_level", level, 16);
    step();
    cmp("ovf_clear", overflow, 0);
    force_busy = 1'b0;
    wait_idle("full_idle");
    check_log("full");

    sent.delete();
    exp_q.delete();
    exp_q.push_back(8'hA0);
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    wait_wait("flush_wait");
    flush = 1'b1;
    step();
    flush = 1'b0;
    cmp("flush_level", level, 0);
    cmp("flush_empty", empty, 1);
    wait_idle("flush_idle");
    check_log("flush");
    wr_en = 1'b1;
    wr_data = 8'h55;
    flush = 1'b1;
    step();
    wr_en = 1'b0;
    flush = 1'b0;
    cmp("flwr_level", level, 0);
    cmp("flwr_ovf", overflow, 0);
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h70);
    wr_en = 1'b1;
    flush = 1'b1;
    step();
    wr_en = 1'b0;
    flush = 1'b0;
    cmp("flfull_ovf", overflow, 0);
    cmp("flfull_level", level, 0);
    force_busy = 1'b0;

    u_dly = 1;
    sent.delete();
    exp_q.delete();
    n = 0;
    k = 0;
    while (n < 40 && k < 2000) begin
      if ($urandom_range(0, 1) == 1 && mq.size() < 2) begin
        b = 8'($urandom);
        wr_en = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        n++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      k++;
    end
    wr_en = 1'b0;
    wait_idle("wrap_idle");
    check_log("wrap");

    for (int i = 0; i < 1500; i++) begin
      wr_en = ($urandom_range(0, 2) != 0);
      wr_data = 8'($urandom);
      flush = ($urandom_range(0, 49) == 0);
      force_busy = ($urandom_range(0, 7) == 0);
      u_dly = $urandom_range(1, 6);
      step();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    force_busy = 1'b0;
    wait_idle("soak_idle");

    u_dly = 100;
    push(8'hC3);
    push(8'h3C);
    push(8'h99);
    wait_wait("rst_wait");
    #1 rst_n = 1'b0;
    #1;
    cmp("rst_send", uart_tx_send, 0);
    cmp("rst_data", uart_tx_data, 8'h00);
    cmp("rst_level", level, 0);
    cmp("rst_empty", empty, 1);
    cmp("rst_full", full, 0);
    cmp("rst_ovf", overflow, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    nb = nsend;
    repeat (10) step();
    cmp("rst_nosend", nsend, nb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and send sequencer that sits directly upstream of uart_tx.
- Producers push bytes with single-cycle write strobes, at any rate up to one per cycle. The block drains them one at a time into uart_tx using the send/done handshake.
- Replaces per-byte handshaking in top-level message FSMs, so a whole message can be queued in a burst.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  push wr_data this cycle
- wr_data  input  8  byte to enqueue
- flush  input  1  synchronous clear of queued (not in-flight) bytes
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- level  output  ADDR_W+1  number of queued bytes, 0..DEPTH
- overflow  output  1  one-cycle pulse: write dropped because full
- uart_tx_send  output  1  one-cycle send request to uart_tx
- uart_tx_data  output  8  byte for uart_tx, valid with send
- uart_tx_done  input  1  one-cycle pulse from uart_tx at end of stop bit
- uart_tx_busy  input  1  uart_tx is transmitting

Behaviour:
- Reset (async, rst_n low) values:
  - rd_ptr = wr_ptr = 0, count = 0.
  - full = 0, empty = 1, level = 0, overflow = 0.
  - uart_tx_send = 0, uart_tx_data = 8'h00, state = IDLE.
  - Memory contents are don't-care.
- Storage: DEPTH x 8 register array, circular.
  - wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
  - count is ADDR_W+1 bits.
  - full, empty and level all derive from registered count.
- Write, sampled at posedge:
  - wr_en && !full && !flush: mem[wr_ptr] <= wr_data, wr_ptr++, count++.
  - wr_en && full && !flush: byte dropped, overflow = 1 for the next cycle only. No pointer change.
  - A pop in the same cycle does NOT free space for a write made while full.
- Flush, sampled at posedge:
  - wr_ptr, rd_ptr and count <= 0.
  - Flush wins over a simultaneous write and a simultaneous pop. Neither takes effect, and no overflow pulse.
  - Does not touch state, uart_tx_send or uart_tx_data. An in-flight byte completes normally.
- Sequencer FSM states:
  - IDLE: if count != 0 && !uart_tx_busy && !flush, then at the next edge: uart_tx_data <= mem[rd_ptr], uart_tx_send <= 1, rd_ptr++, count-- (pop), state <= SEND.
  - SEND: uart_tx_send <= 0, state <= WAIT. The send pulse is exactly 1 cycle wide.
  - WAIT: on uart_tx_done == 1, state <= IDLE. Otherwise hold.
  - Default/illegal state -> IDLE.
- uart_tx_data holds the last sent byte until the next pop.
- uart_tx_done is ignored in IDLE and SEND.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency:
  - A write at edge N into an empty FIFO, with uart_tx idle, gives uart_tx_send high in the cycle after edge N+1.
  - Between bytes: done seen at edge M gives the next send high after edge M+1. The gap is 1 idle cycle in IDLE.
- Ordering: strict FIFO; bytes are never reordered or duplicated.
- Reset mid-operation: all state returns to reset values immediately. Queued bytes are lost, and no send pulse is produced during or directly after reset.

Test Plan:
- Reset, then idle 20 cycles -> empty=1, level=0, uart_tx_send never high, uart_tx_data=8'h00.
- Push 8'h42 once (uart_tx model idle) -> level=1 for one cycle; uart_tx_send high exactly 1 cycle with uart_tx_data=8'h42, 2 cycles after the write edge; level returns to 0.
- Burst-push "Baptiste !\n" (11 bytes, 8'h42..8'h0A) on consecutive cycles, with a uart_tx model asserting done 100 cycles after each send -> 11 send pulses in order, each preceded by done; empty=1 after the last.
- Hold uart_tx_busy=1, push 17 bytes 8'h00..8'h10 -> full=1 after 16; 17th write gives overflow=1 for one cycle and level stays 16. Release busy -> bytes 8'h00..8'h0F emitted; 8'h10 never emitted.
- Push 4 bytes; assert flush while byte 0 is in WAIT -> level=0 next cycle; byte 0's done still returns FSM to IDLE; no further sends. Flush with wr_en in the same cycle -> level=0, no overflow.
- Wrap/simultaneous: keep level near 1 with push and pop in the same cycle over 40 bytes (pointer wrap x2) -> output sequence matches input sequence exactly. Assert rst_n low mid-WAIT -> all outputs reach reset values asynchronously.
